// File: rtl/sap1_pkg.sv
// +--------------------------------------------------------------------------+
// | sap1_pkg : shared opcodes, sequencer states and control word for SAP-1    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      T1   = 3'd0,
      T2   = 3'd1,
      T3   = 3'd2,
      T4   = 3'd3,
      T5   = 3'd4,
      T6   = 3'd5,
      HALT = 3'd6
   } t_state_e;

   // Field order matches the classic SAP-1 control word listing.
   typedef struct packed {
      logic cp;
      logic ep;
      logic lm_n;
      logic ce_n;
      logic li_n;
      logic ei_n;
      logic la_n;
      logic ea;
      logic su;
      logic eu;
      logic lb_n;
      logic lo_n;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_IDLE = '{
      cp: 1'b0, ep: 1'b0, lm_n: 1'b1, ce_n: 1'b1, li_n: 1'b1, ei_n: 1'b1,
      la_n: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, lb_n: 1'b1, lo_n: 1'b1
   };

endpackage

`default_nettype wire

// File: rtl/sap1_ring_counter.sv
// +--------------------------------------------------------------------------+
// | sap1_ring_counter : T1..T6 ring sequencer with sticky HALT state         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       halt_req,
   output logic [2:0] state
);

   t_state_e state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= T1;
      end else begin
         unique case (state_q)
            T1:      state_q <= T2;
            T2:      state_q <= T3;
            T3:      state_q <= T4;
            T4:      state_q <= halt_req ? HALT : T5;
            T5:      state_q <= T6;
            T6:      state_q <= T1;
            HALT:    state_q <= HALT;
            default: state_q <= T1;
         endcase
      end
   end

   assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/sap1_controller.sv
// +--------------------------------------------------------------------------+
// | sap1_controller : SAP-1 instruction register and control-word decoder    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module sap1_controller
   import sap1_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] W,
   output logic       Cp,
   output logic       Ep,
   output logic       Lm_barra,
   output logic       CE_barra,
   output logic       Li_barra,
   output logic       Ei_barra,
   output logic       La_barra,
   output logic       Ea,
   output logic       Su,
   output logic       Eu,
   output logic       Lb_barra,
   output logic       Lo_barra,
   output logic [3:0] ir_opcode,
   output logic [3:0] ir_operand,
   output logic       halted
);

   logic [7:0] ir_q;
   logic [2:0] state_raw;
   t_state_e   state;
   logic       halt_req;
   ctrl_word_t ctrl;
   ctrl_word_t ctrl_o;

   assign state    = t_state_e'(state_raw);
   assign halt_req = (state == T4) && (ir_q[7:4] == OP_HLT);

   sap1_ring_counter u_ring (
      .clk      (clk),
      .rst      (rst),
      .halt_req (halt_req),
      .state    (state_raw)
   );

   // IR only samples W during T3, so garbage on W elsewhere never reaches it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q <= 8'h00;
      end else if (state == T3) begin
         ir_q <= W;
      end
   end

   always_comb begin
      ctrl = CTRL_IDLE;
      unique case (state)
         T1: begin
            ctrl.ep   = 1'b1;
            ctrl.lm_n = 1'b0;
         end
         T2: ctrl.cp = 1'b1;
         T3: begin
            ctrl.ce_n = 1'b0;
            ctrl.li_n = 1'b0;
         end
         T4: begin
            if (ir_q[7:4] == OP_LDA || ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
               ctrl.lm_n = 1'b0;
               ctrl.ei_n = 1'b0;
            end else if (ir_q[7:4] == OP_OUT) begin
               ctrl.ea   = 1'b1;
               ctrl.lo_n = 1'b0;
            end
         end
         T5: begin
            if (ir_q[7:4] == OP_LDA) begin
               ctrl.ce_n = 1'b0;
               ctrl.la_n = 1'b0;
            end else if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
               ctrl.ce_n = 1'b0;
               ctrl.lb_n = 1'b0;
               ctrl.su   = (ir_q[7:4] == OP_SUB);
            end
         end
         T6: begin
            if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
               ctrl.eu   = 1'b1;
               ctrl.la_n = 1'b0;
               ctrl.su   = (ir_q[7:4] == OP_SUB);
            end
         end
         default: ctrl = CTRL_IDLE;
      endcase
   end

   // Reset overrides the decode so nothing pulses while rst is held.
   assign ctrl_o = rst ? CTRL_IDLE : ctrl;

   assign Cp         = ctrl_o.cp;
   assign Ep         = ctrl_o.ep;
   assign Lm_barra   = ctrl_o.lm_n;
   assign CE_barra   = ctrl_o.ce_n;
   assign Li_barra   = ctrl_o.li_n;
   assign Ei_barra   = ctrl_o.ei_n;
   assign La_barra   = ctrl_o.la_n;
   assign Ea         = ctrl_o.ea;
   assign Su         = ctrl_o.su;
   assign Eu         = ctrl_o.eu;
   assign Lb_barra   = ctrl_o.lb_n;
   assign Lo_barra   = ctrl_o.lo_n;
   assign ir_opcode  = ir_q[7:4];
   assign ir_operand = ir_q[3:0];
   assign halted     = !rst && (state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_sap1_controller.sv
// +--------------------------------------------------------------------------+
// | tb_sap1_controller : directed self-checking bench for sap1_controller    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_sap1_controller;

   // Control vector order: Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
   localparam logic [11:0] IDLE = 12'b0011_1110_0011;
   localparam logic [11:0] M_CP = 12'b1000_0000_0000;
   localparam logic [11:0] M_EP = 12'b0100_0000_0000;
   localparam logic [11:0] M_LM = 12'b0010_0000_0000;
   localparam logic [11:0] M_CE = 12'b0001_0000_0000;
   localparam logic [11:0] M_LI = 12'b0000_1000_0000;
   localparam logic [11:0] M_EI = 12'b0000_0100_0000;
   localparam logic [11:0] M_LA = 12'b0000_0010_0000;
   localparam logic [11:0] M_EA = 12'b0000_0001_0000;
   localparam logic [11:0] M_SU = 12'b0000_0000_1000;
   localparam logic [11:0] M_EU = 12'b0000_0000_0100;
   localparam logic [11:0] M_LB = 12'b0000_0000_0010;
   localparam logic [11:0] M_LO = 12'b0000_0000_0001;

   logic       clk;
   logic       rst;
   logic [7:0] W;
   logic       Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra, La_barra;
   logic       Ea, Su, Eu, Lb_barra, Lo_barra, halted;
   logic [3:0] ir_opcode, ir_operand;

   int checks = 0;
   int errors = 0;

   sap1_controller dut (
      .clk        (clk),
      .rst        (rst),
      .W          (W),
      .Cp         (Cp),
      .Ep         (Ep),
      .Lm_barra   (Lm_barra),
      .CE_barra   (CE_barra),
      .Li_barra   (Li_barra),
      .Ei_barra   (Ei_barra),
      .La_barra   (La_barra),
      .Ea         (Ea),
      .Su         (Su),
      .Eu         (Eu),
      .Lb_barra   (Lb_barra),
      .Lo_barra   (Lo_barra),
      .ir_opcode  (ir_opcode),
      .ir_operand (ir_operand),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_ir(input string tag, input logic [7:0] exp);
      chk(tag, {4'h0, ir_opcode, ir_operand}, {4'h0, exp});
   endtask

   // Checks one cycle's outputs mid-cycle, then advances to the next falling edge.
   task automatic cyc(input logic [11:0] e, input logic h, input string tag);
      int drv;
      #1;
      chk({tag, "_ctrl"}, {Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra,
                           La_barra, Ea, Su, Eu, Lb_barra, Lo_barra}, e);
      chk({tag, "_halted"}, {11'h0, halted}, {11'h0, h});
      drv = int'(Ep === 1'b1) + int'(CE_barra === 1'b0) + int'(Ei_barra === 1'b0)
          + int'(Ea === 1'b1) + int'(Eu === 1'b1);
      chk({tag, "_busdrv"}, {11'h0, drv <= 1}, 12'h001);
      @(negedge clk);
   endtask

   task automatic fetch(input logic [7:0] w, input string tag);
      cyc(IDLE ^ M_EP ^ M_LM, 1'b0, {tag, "_T1"});
      cyc(IDLE ^ M_CP, 1'b0, {tag, "_T2"});
      W = w;
      cyc(IDLE ^ M_CE ^ M_LI, 1'b0, {tag, "_T3"});
      W = 8'hxx;
      chk_ir({tag, "_ir"}, w);
   endtask

   task automatic instr(input logic [7:0] w, input logic [11:0] e4, input logic [11:0] e5,
                        input logic [11:0] e6, input string tag);
      fetch(w, tag);
      cyc(e4, 1'b0, {tag, "_T4"});
      cyc(e5, 1'b0, {tag, "_T5"});
      cyc(e6, 1'b0, {tag, "_T6"});
   endtask

   initial begin
      rst = 1'b1;
      W   = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_ir("rst_ir", 8'h00);
      cyc(IDLE, 1'b0, "rst");
      rst = 1'b0;

      instr(8'h06, IDLE ^ M_LM ^ M_EI, IDLE ^ M_CE ^ M_LA, IDLE, "lda");
      instr(8'h17, IDLE ^ M_LM ^ M_EI, IDLE ^ M_CE ^ M_LB, IDLE ^ M_EU ^ M_LA, "add");
      instr(8'h29, IDLE ^ M_LM ^ M_EI, IDLE ^ M_CE ^ M_LB ^ M_SU,
            IDLE ^ M_EU ^ M_LA ^ M_SU, "sub");
      instr(8'h50, IDLE, IDLE, IDLE, "nop");

      // Reset landing in the middle of T5 of an ADD.
      fetch(8'h17, "add2");
      cyc(IDLE ^ M_LM ^ M_EI, 1'b0, "add2_T4");
      rst = 1'b1;
      cyc(IDLE, 1'b0, "rst_t5");
      rst = 1'b0;
      chk_ir("rst_t5_ir", 8'h00);

      instr(8'h03, IDLE ^ M_LM ^ M_EI, IDLE ^ M_CE ^ M_LA, IDLE, "lda2");
      instr(8'hE0, IDLE ^ M_EA ^ M_LO, IDLE, IDLE, "out");

      fetch(8'hF0, "hlt");
      cyc(IDLE, 1'b0, "hlt_T4");
      for (int i = 0; i < 22; i++) cyc(IDLE, 1'b1, "halt");

      rst = 1'b1;
      cyc(IDLE, 1'b0, "rst_halt");
      rst = 1'b0;
      chk_ir("rst_halt_ir", 8'h00);
      instr(8'h0A, IDLE ^ M_LM ^ M_EI, IDLE ^ M_CE ^ M_LA, IDLE, "lda3");
      cyc(IDLE ^ M_EP ^ M_LM, 1'b0, "wrap_T1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
